// File: rtl/bank_pkg.sv
// Shared definitions for the bank read crossbar.
// Mode encodings, FSM states and default geometry.
package bank_pkg;

  localparam logic MODE_NTT = 1'b0;
  localparam logic MODE_MSM = 1'b1;

  localparam int DEF_DW     = 256;
  localparam int DEF_N_BANK = 44;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH
  } state_t;

endpackage

// File: rtl/bank_rd_sel_pipe.sv
// Select/mode shift pipeline matched to the bank read latency.
// Also tracks requests accepted but not yet presented on the output.
module bank_rd_sel_pipe #(
  parameter int N_OUT    = 16,
  parameter int IP_LANES = 4,
  parameter int RD_LAT   = 1,
  parameter int SW       = 6,
  parameter int CW       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc,
  input  logic                   done,
  input  logic [N_OUT*SW-1:0]    sel,
  input  logic [IP_LANES*SW-1:0] ip_sel,
  input  logic                   mode,
  output logic                   out_vld,
  output logic [N_OUT*SW-1:0]    out_sel,
  output logic [IP_LANES*SW-1:0] out_ip_sel,
  output logic                   out_mode,
  output logic [CW-1:0]          inflight
);

  logic [RD_LAT-1:0]      vld_q;
  logic [RD_LAT-1:0]      mode_q;
  logic [N_OUT*SW-1:0]    sel_q [RD_LAT];
  logic [IP_LANES*SW-1:0] ip_q  [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        sel_q[i] <= '0;
        ip_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= acc;
      mode_q[0] <= mode;
      sel_q[0]  <= sel;
      ip_q[0]   <= ip_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        mode_q[i] <= mode_q[i-1];
        sel_q[i]  <= sel_q[i-1];
        ip_q[i]   <= ip_q[i-1];
      end
    end
  end

  // Simultaneous accept and retire leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({acc, done})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign out_vld    = vld_q[RD_LAT-1];
  assign out_mode   = mode_q[RD_LAT-1];
  assign out_sel    = sel_q[RD_LAT-1];
  assign out_ip_sel = ip_q[RD_LAT-1];

endmodule

// File: rtl/bank_rd_xbar.sv
// Bank read crossbar onto NTT/MSM lanes with drain-then-switch mode FSM.
// Define BANK_RD_XBAR_PERF_EN to add saturating request/drain counters.
module bank_rd_xbar
  import bank_pkg::*;
#(
  parameter int  DW       = DEF_DW,
  parameter int  N_BANK   = DEF_N_BANK,
  parameter int  N_OUT    = 16,
  parameter int  IP_LANES = 4,
  parameter int  RD_LAT   = 1,
  localparam int SW       = $clog2(N_BANK),
  localparam int CW       = $clog2(RD_LAT + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [N_OUT*SW-1:0]    req_sel,
  input  logic [IP_LANES*SW-1:0] req_ip_sel,
  input  logic [N_BANK*DW-1:0]   din,
  input  logic                   mode_sw_req,
  input  logic                   mode_tgt,
  output logic                   mode_sw_ack,
  output logic                   mode,
  output logic [N_OUT*DW-1:0]    dout,
  output logic                   dout_vld,
  output logic [IP_LANES*DW-1:0] dout_ip,
  output logic                   dout_ip_vld,
  output logic [CW-1:0]          inflight,
  output logic                   sel_err
`ifdef BANK_RD_XBAR_PERF_EN
  ,
  output logic [31:0]            perf_req_cnt,
  output logic [31:0]            perf_drain_cnt
`endif
);

  state_t state, state_nxt;
  logic   same_ack, same_nxt;
  logic   acc;

  logic                   p_vld, p_mode;
  logic [N_OUT*SW-1:0]    p_sel;
  logic [IP_LANES*SW-1:0] p_ip_sel;

  logic [DW-1:0]          bank [N_BANK];
  logic [N_OUT*DW-1:0]    lane_d;
  logic [IP_LANES*DW-1:0] ip_d;
  logic                   bad;

  assign req_rdy     = (state == RUN) & ~rst;
  assign acc         = req_vld & req_rdy;
  assign mode_sw_ack = same_ack | (state == SWITCH);

  always_comb begin
    state_nxt = state;
    same_nxt  = 1'b0;
    unique case (state)
      RUN: begin
        if (mode_sw_req) begin
          if (mode_tgt == mode) same_nxt  = 1'b1;
          else                  state_nxt = DRAIN;
        end
      end
      DRAIN:   if (inflight == '0) state_nxt = SWITCH;
      SWITCH:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      same_ack <= 1'b0;
      mode     <= MODE_NTT;
    end else begin
      state    <= state_nxt;
      same_ack <= same_nxt;
      if (state == SWITCH) mode <= mode_tgt;
    end
  end

  bank_rd_sel_pipe #(
    .N_OUT(N_OUT), .IP_LANES(IP_LANES), .RD_LAT(RD_LAT),
    .SW(SW), .CW(CW)
  ) u_pipe (
    .clk(clk), .rst(rst), .acc(acc), .done(dout_vld),
    .sel(req_sel), .ip_sel(req_ip_sel), .mode(mode),
    .out_vld(p_vld), .out_sel(p_sel), .out_ip_sel(p_ip_sel),
    .out_mode(p_mode), .inflight(inflight)
  );

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    assign bank[b] = din[b*DW +: DW];
  end

  function automatic logic oob(input logic [SW-1:0] s);
    return int'(s) >= N_BANK;
  endfunction

  function automatic logic [DW-1:0] pick(input logic [SW-1:0] s);
    return oob(s) ? '0 : bank[s];
  endfunction

  // IP lane 0 lands in the most significant word.
  always_comb begin
    lane_d = '0;
    ip_d   = '0;
    bad    = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      lane_d[k*DW +: DW] = pick(p_sel[k*SW +: SW]);
      bad = bad | oob(p_sel[k*SW +: SW]);
    end
    for (int j = 0; j < IP_LANES; j++) begin
      ip_d[(IP_LANES-1-j)*DW +: DW] = pick(p_ip_sel[j*SW +: SW]);
      if (p_mode == MODE_MSM) bad = bad | oob(p_ip_sel[j*SW +: SW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      dout_ip     <= '0;
      dout_vld    <= 1'b0;
      dout_ip_vld <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      dout_vld    <= p_vld;
      dout_ip_vld <= p_vld & (p_mode == MODE_MSM);
      if (p_vld) begin
        dout    <= lane_d;
        dout_ip <= (p_mode == MODE_MSM) ? ip_d : '0;
        if (bad) sel_err <= 1'b1;
      end
    end
  end

`ifdef BANK_RD_XBAR_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_req_cnt   <= '0;
      perf_drain_cnt <= '0;
    end else begin
      if (acc && !(&perf_req_cnt))
        perf_req_cnt <= perf_req_cnt + 32'd1;
      if ((state != RUN) && !(&perf_drain_cnt))
        perf_drain_cnt <= perf_drain_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bank_rd_xbar.sv
// Directed bench for bank_rd_xbar.
// Instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_bank_rd_xbar;

  localparam int DW  = 16;
  localparam int NB  = 44;
  localparam int NO  = 16;
  localparam int IPL = 4;
  localparam int SW  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NB*DW-1:0] din;

  logic              a_vld, a_rdy, a_swreq, a_tgt, a_ack, a_mode;
  logic [NO*SW-1:0]  a_sel;
  logic [IPL*SW-1:0] a_ip;
  logic [NO*DW-1:0]  a_dout;
  logic [IPL*DW-1:0] a_dip;
  logic              a_dvld, a_ipvld, a_err;
  logic [1:0]        a_infl;

  logic              b_vld, b_rdy, b_swreq, b_tgt, b_ack, b_mode;
  logic [NO*SW-1:0]  b_sel;
  logic [IPL*SW-1:0] b_ip;
  logic [NO*DW-1:0]  b_dout;
  logic [IPL*DW-1:0] b_dip;
  logic              b_dvld, b_ipvld, b_err;
  logic [2:0]        b_infl;

  bank_rd_xbar #(
    .DW(DW), .N_BANK(NB), .N_OUT(NO), .IP_LANES(IPL), .RD_LAT(1)
  ) u_a (
    .clk(clk), .rst(rst), .req_vld(a_vld), .req_rdy(a_rdy),
    .req_sel(a_sel), .req_ip_sel(a_ip), .din(din),
    .mode_sw_req(a_swreq), .mode_tgt(a_tgt), .mode_sw_ack(a_ack),
    .mode(a_mode), .dout(a_dout), .dout_vld(a_dvld),
    .dout_ip(a_dip), .dout_ip_vld(a_ipvld),
    .inflight(a_infl), .sel_err(a_err)
  );

  bank_rd_xbar #(
    .DW(DW), .N_BANK(NB), .N_OUT(NO), .IP_LANES(IPL), .RD_LAT(3)
  ) u_b (
    .clk(clk), .rst(rst), .req_vld(b_vld), .req_rdy(b_rdy),
    .req_sel(b_sel), .req_ip_sel(b_ip), .din(din),
    .mode_sw_req(b_swreq), .mode_tgt(b_tgt), .mode_sw_ack(b_ack),
    .mode(b_mode), .dout(b_dout), .dout_vld(b_dvld),
    .dout_ip(b_dip), .dout_ip_vld(b_ipvld),
    .inflight(b_infl), .sel_err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] w(input int b);
    return (b < NB) ? {2{8'(b)}} : '0;
  endfunction

  function automatic logic [NO*SW-1:0] mk_sel(input int base);
    logic [NO*SW-1:0] s;
    s = '0;
    for (int k = 0; k < NO; k++) s[k*SW +: SW] = SW'((base + k) % NB);
    return s;
  endfunction

  function automatic logic [NO*DW-1:0] exp_dout(input logic [NO*SW-1:0] s);
    logic [NO*DW-1:0] d;
    d = '0;
    for (int k = 0; k < NO; k++) d[k*DW +: DW] = w(int'(s[k*SW +: SW]));
    return d;
  endfunction

  logic [IPL*SW-1:0] ip_a;
  logic [IPL*DW-1:0] ip_exp;
  logic [NO*SW-1:0]  hist [10];
  int peak;

  initial begin
    ip_a   = {6'd41, 6'd30, 6'd19, 6'd8};
    ip_exp = 64'h0808_1313_1e1e_2929;
    for (int b = 0; b < NB; b++) din[b*DW +: DW] = {2{8'(b)}};
    rst = 1'b1;
    a_vld = 0; a_sel = '0; a_ip = '0; a_swreq = 0; a_tgt = 0;
    b_vld = 0; b_sel = '0; b_ip = '0; b_swreq = 0; b_tgt = 0;
    tick();
    tick();
    chk("rst_dout",  a_dout, '0);
    chk("rst_dvld",  a_dvld, 0);
    chk("rst_dip",   a_dip, '0);
    chk("rst_mode",  a_mode, 0);
    chk("rst_infl",  b_infl, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_rdy",   a_rdy, 0);
    chk("rst_ack",   b_ack, 0);
    rst = 1'b0;
    tick();
    chk("run_rdy", a_rdy, 1);

    // NTT request, latency 2 at RD_LAT=1
    a_vld = 1; a_sel = mk_sel(4);
    tick();
    a_vld = 0;
    chk("ntt_infl1", a_infl, 1);
    chk("ntt_vld_early", a_dvld, 0);
    tick();
    chk("ntt_dout", a_dout, exp_dout(mk_sel(4)));
    chk("ntt_lane0", a_dout[15:0], 16'h0404);
    chk("ntt_dvld", a_dvld, 1);
    chk("ntt_dip", a_dip, '0);
    chk("ntt_ipvld", a_ipvld, 0);
    tick();
    chk("ntt_dvld_off", a_dvld, 0);
    chk("ntt_infl0", a_infl, 0);
    chk("ntt_hold", a_dout, exp_dout(mk_sel(4)));

    // switch to MSM with nothing in flight
    a_swreq = 1; a_tgt = 1;
    tick();
    chk("sw_drain_rdy", a_rdy, 0);
    chk("sw_drain_ack", a_ack, 0);
    tick();
    chk("sw_ack", a_ack, 1);
    chk("sw_rdy", a_rdy, 0);
    chk("sw_mode_old", a_mode, 0);
    a_swreq = 0;
    tick();
    chk("sw_mode_new", a_mode, 1);
    chk("sw_ack_off", a_ack, 0);
    chk("sw_rdy_back", a_rdy, 1);

    // MSM request with ip selects 8,19,30,41
    a_vld = 1; a_sel = mk_sel(0); a_ip = ip_a;
    tick();
    a_vld = 0;
    tick();
    chk("msm_dip", a_dip, ip_exp);
    chk("msm_ipvld", a_ipvld, 1);
    chk("msm_dvld", a_dvld, 1);
    chk("msm_dout", a_dout, exp_dout(mk_sel(0)));

    // same-mode request acks next cycle without draining
    a_swreq = 1; a_tgt = 1;
    tick();
    chk("same_ack", a_ack, 1);
    chk("same_rdy", a_rdy, 1);
    a_swreq = 0;
    tick();
    chk("same_ack_off", a_ack, 0);
    chk("same_mode", a_mode, 1);

    // out-of-range select on lane 2
    chk("err_before", a_err, 0);
    a_sel = mk_sel(0);
    a_sel[2*SW +: SW] = 6'd50;
    a_vld = 1;
    tick();
    a_vld = 0;
    tick();
    chk("oob_lane2", a_dout[2*DW +: DW], 16'h0000);
    chk("oob_lane3", a_dout[3*DW +: DW], 16'h0303);
    chk("oob_dout", a_dout, exp_dout(a_sel));
    chk("oob_err", a_err, 1);
    a_sel = mk_sel(10); a_vld = 1;
    tick();
    a_vld = 0;
    tick();
    chk("oob_next", a_dout, exp_dout(mk_sel(10)));
    chk("oob_sticky", a_err, 1);

    // back-to-back 10 requests at RD_LAT=3
    peak = 0;
    for (int c = 0; c < 16; c++) begin
      b_vld = (c < 10);
      if (c < 10) begin
        b_sel = mk_sel(3 * c);
        hist[c] = b_sel;
      end
      chk("b2b_vld", b_dvld, (c >= 4 && c < 14));
      if (c >= 4 && c < 14) chk("b2b_dout", b_dout, exp_dout(hist[c-4]));
      if (int'(b_infl) > peak) peak = int'(b_infl);
      tick();
    end
    b_vld = 0;
    chk("b2b_peak", peak, 4);
    chk("b2b_infl0", b_infl, 0);

    // NTT->MSM switch with 3 requests in flight
    b_ip = ip_a; b_tgt = 1;
    for (int c = 0; c < 14; c++) begin
      b_vld = (c <= 9);
      b_sel = mk_sel(5 * c);
      if (c < 10) hist[c] = b_sel;
      b_swreq = (c >= 2 && c <= 8);
      chk("drn_rdy", b_rdy, (c <= 2 || c >= 9));
      chk("drn_ack", b_ack, (c == 8));
      chk("drn_mode", b_mode, (c >= 9));
      chk("drn_dvld", b_dvld, ((c >= 4 && c <= 6) || c == 13));
      chk("drn_ipvld", b_ipvld, (c == 13));
      if (c == 3) chk("drn_infl3", b_infl, 3);
      if (c == 7) chk("drn_infl0", b_infl, 0);
      if (c >= 4 && c <= 6) chk("drn_old", b_dout, exp_dout(hist[c-4]));
      if (c == 13) begin
        chk("drn_new", b_dout, exp_dout(hist[9]));
        chk("drn_dip", b_dip, ip_exp);
      end
      tick();
    end
    b_vld = 0;

    // reset during DRAIN with two requests in flight
    b_vld = 1; b_sel = mk_sel(7);
    tick();
    b_sel = mk_sel(9); b_swreq = 1; b_tgt = 0;
    tick();
    b_vld = 0;
    chk("rd_rdy", b_rdy, 0);
    chk("rd_infl2", b_infl, 2);
    chk("rd_mode1", b_mode, 1);
    chk("rd_dout_pre", b_dout, exp_dout(hist[9]));
    rst = 1'b1;
    #1;
    chk("rd_dout", b_dout, '0);
    chk("rd_dip", b_dip, '0);
    chk("rd_dvld", b_dvld, 0);
    chk("rd_mode", b_mode, 0);
    chk("rd_infl", b_infl, 0);
    b_swreq = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("rd_no_vld", b_dvld, 0);
      tick();
    end
    chk("rd_infl_end", b_infl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
